// File: rtl/sys_cmd_pkg.sv
// Shared constants for the command host: frame opcodes, command types, FSM states.
package sys_cmd_pkg;

    // Frame opcodes, one per command type
    localparam logic [7:0] OP_RF_WR  = 8'hAA;
    localparam logic [7:0] OP_RF_RD  = 8'hBB;
    localparam logic [7:0] OP_ALU_AB = 8'hCC;
    localparam logic [7:0] OP_ALU_FN = 8'hDD;

    typedef enum logic [1:0] {
        CmdRfWr  = 2'd0,
        CmdRfRd  = 2'd1,
        CmdAluAb = 2'd2,
        CmdAluFn = 2'd3
    } cmd_type_e;

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StSend    = 2'd1;
    localparam logic [1:0] StWaitRsp = 2'd2;
    localparam logic [1:0] StDone    = 2'd3;

    // Number of bytes in the outgoing frame
    function automatic logic [2:0] frame_len(input cmd_type_e t);
        case (t)
            CmdRfWr:  frame_len = 3'd3;
            CmdRfRd:  frame_len = 3'd2;
            CmdAluAb: frame_len = 3'd4;
            default:  frame_len = 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/cmd_byte_sel.sv
// Combinational frame-byte lookup: picks the byte at idx_i for the captured command.
module cmd_byte_sel
    import sys_cmd_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned RfAddr    = 4
) (
    input  cmd_type_e            type_i,
    input  logic [RfAddr-1:0]    addr_i,
    input  logic [DataWidth-1:0] a_i,
    input  logic [DataWidth-1:0] b_i,
    input  logic [3:0]           fun_i,
    input  logic [1:0]           idx_i,
    output logic [DataWidth-1:0] byte_o,
    output logic [2:0]           len_o
);

    // Frame byte selection; out-of-range indices give zero
    always_comb begin
        byte_o = '0;
        len_o  = frame_len(type_i);
        case (type_i)
            CmdRfWr: begin
                case (idx_i)
                    2'd0:    byte_o = DataWidth'(OP_RF_WR);
                    2'd1:    byte_o = DataWidth'(addr_i);
                    2'd2:    byte_o = a_i;
                    default: byte_o = '0;
                endcase
            end
            CmdRfRd: begin
                case (idx_i)
                    2'd0:    byte_o = DataWidth'(OP_RF_RD);
                    2'd1:    byte_o = DataWidth'(addr_i);
                    default: byte_o = '0;
                endcase
            end
            CmdAluAb: begin
                case (idx_i)
                    2'd0:    byte_o = DataWidth'(OP_ALU_AB);
                    2'd1:    byte_o = a_i;
                    2'd2:    byte_o = b_i;
                    default: byte_o = DataWidth'(fun_i);
                endcase
            end
            default: begin
                case (idx_i)
                    2'd0:    byte_o = DataWidth'(OP_ALU_FN);
                    2'd1:    byte_o = DataWidth'(fun_i);
                    default: byte_o = '0;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/cmd_host.sv
// Command host: frames a captured command onto the UART TX side and collects the response.
module cmd_host
    import sys_cmd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned RF_ADDR     = 4,
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic [1:0]              CMD_TYPE,
    input  logic [RF_ADDR-1:0]      CMD_ADDR,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA_A,
    input  logic [DATA_WIDTH-1:0]   CMD_DATA_B,
    input  logic [3:0]              CMD_FUN,
    output logic [DATA_WIDTH-1:0]   TX_DATA,
    output logic                    TX_VALID,
    input  logic                    TX_READY,
    input  logic [DATA_WIDTH-1:0]   RX_DATA,
    input  logic                    RX_VALID,
    output logic [2*DATA_WIDTH-1:0] RSP_DATA,
    output logic                    RSP_VALID,
    output logic                    RSP_TIMEOUT,
    output logic                    BUSY
);

    logic [1:0]              state_q, state_d;
    cmd_type_e               type_q, type_d;
    logic [RF_ADDR-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [3:0]              fun_q, fun_d;
    logic [1:0]              idx_q, idx_d;
    logic                    rx_cnt_q, rx_cnt_d;
    logic [15:0]             tmo_q, tmo_d;
    logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic [DATA_WIDTH-1:0]   sel_byte;
    logic [2:0]              sel_len;
    logic                    last_byte;

    cmd_byte_sel #(
        .DataWidth (DATA_WIDTH),
        .RfAddr    (RF_ADDR)
    ) u_byte_sel (
        .type_i (type_q),
        .addr_i (addr_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .fun_i  (fun_q),
        .idx_i  (idx_q),
        .byte_o (sel_byte),
        .len_o  (sel_len)
    );

    assign last_byte = ({1'b0, idx_q} == (sel_len - 3'd1));

    // Outputs decoded from state; TX_DATA reads zero outside SEND
    always_comb begin
        CMD_READY   = (state_q == StIdle);
        TX_VALID    = (state_q == StSend);
        TX_DATA     = (state_q == StSend) ? sel_byte : '0;
        RSP_VALID   = (state_q == StDone);
        RSP_DATA    = rsp_data_q;
        RSP_TIMEOUT = rsp_timeout_q;
        BUSY        = (state_q != StIdle);
    end

    // Next-state: command capture, frame sequencing, response collection and timeout
    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        addr_d        = addr_q;
        a_d           = a_q;
        b_d           = b_q;
        fun_d         = fun_q;
        idx_d         = idx_q;
        rx_cnt_d      = rx_cnt_q;
        tmo_d         = tmo_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (CMD_VALID) begin
                    type_d     = cmd_type_e'(CMD_TYPE);
                    addr_d     = CMD_ADDR;
                    a_d        = CMD_DATA_A;
                    b_d        = CMD_DATA_B;
                    fun_d      = CMD_FUN;
                    idx_d      = 2'd0;
                    // Clearing here gives type 0 a zero response and type 1 a zero high byte
                    rsp_data_d = '0;
                    state_d    = StSend;
                end
            end
            StSend: begin
                if (TX_READY) begin
                    if (last_byte) begin
                        idx_d    = 2'd0;
                        tmo_d    = '0;
                        rx_cnt_d = 1'b0;
                        state_d  = (type_q == CmdRfWr) ? StDone : StWaitRsp;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            StWaitRsp: begin
                // A byte arriving on the timeout cycle still counts
                if (RX_VALID) begin
                    tmo_d    = '0;
                    rx_cnt_d = 1'b1;
                    if (!rx_cnt_q) begin
                        rsp_data_d[DATA_WIDTH-1:0] = RX_DATA;
                    end else begin
                        rsp_data_d[2*DATA_WIDTH-1:DATA_WIDTH] = RX_DATA;
                    end
                    if (rx_cnt_q || (type_q == CmdRfRd)) begin
                        state_d = StDone;
                    end
                end else if (tmo_q == (TIMEOUT_CYC - 16'd1)) begin
                    rsp_timeout_d = 1'b1;
                    state_d       = StIdle;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIdle;
            type_q        <= CmdRfWr;
            addr_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            fun_q         <= '0;
            idx_q         <= '0;
            rx_cnt_q      <= 1'b0;
            tmo_q         <= '0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            a_q           <= a_d;
            b_q           <= b_d;
            fun_q         <= fun_d;
            idx_q         <= idx_d;
            rx_cnt_q      <= rx_cnt_d;
            tmo_q         <= tmo_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

endmodule
